pipe_skid_stage: RTL and testbench

- Parametrised pipeline-stage register that replaces hand-written per-stage latch banks between EX, MEM and WB.
- Carries a control vector and a data vector using a valid/ready handshake.
- A 2-entry skid buffer provides full throughput under backpressure. Synchronous flush squashes in-flight instructions.
- Control bits read as zero whenever the stage holds no valid entry, so downstream stages see a bubble.

---
 rtl/pipe_skid_stage.sv | 166 ++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with a 2-entry skid buffer, valid/ready handshake and synchronous flush.
// Optional stall statistics counter enabled by defining PIPE_SKID_STAGE_STATS_EN.
module pipe_skid_stage #(
  parameter int unsigned          CTRL_W     = 48,
  parameter int unsigned          DATA_W     = 101,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occupancy_q, occupancy_d;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_q;
  assign pop  = main_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Squash both entries; a same-cycle push is dropped.
      state_d      = StEmpty;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
      main_data_d  = RESET_DATA;
      skid_data_d  = RESET_DATA;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d      = StOne;
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end
        end
        StOne: begin
          if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (push) begin
            state_d      = StFull;
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end else if (pop) begin
            // Data is kept so out_data holds the last drained value.
            state_d      = StEmpty;
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
          end
        end
        StFull: begin
          if (pop) begin
            state_d      = StOne;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
          end
        end
        default: begin
          state_d      = StEmpty;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          main_ctrl_d  = '0;
          skid_ctrl_d  = '0;
        end
      endcase
    end

    in_ready_d  = ~skid_valid_d;
    occupancy_d = state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= RESET_DATA;
      skid_data_q  <= RESET_DATA;
      in_ready_q   <= 1'b1;
      occupancy_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      occupancy_q  <= occupancy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = occupancy_q;

`ifdef PIPE_SKID_STAGE_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Counts edges where the head is held by backpressure; saturates, ignores flush.
  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a FIFO scoreboard on the output.
module tb_pipe_skid_stage;

  localparam int CW = 48;
  localparam int DW = 101;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_count;

  int checks = 0;
  int errors = 0;
  entry_t sb[$];
  logic [DW-1:0] last_data;

  pipe_skid_stage dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  // Scoreboard and per-cycle invariants, sampled mid-cycle while inputs are stable.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        entry_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got ctrl=%0h with nothing expected", out_ctrl);
        end else begin
          e = sb.pop_front();
          if (out_ctrl !== e.ctrl || out_data !== e.data) begin
            errors++;
            $display("FAIL sb_order: got ctrl=%0h data=%0h, want ctrl=%0h data=%0h",
                     out_ctrl, out_data, e.ctrl, e.data);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{ctrl: in_ctrl, data: in_data});

      checks++;
      if (dut.skid_valid_q && !dut.main_valid_q) begin
        errors++;
        $display("FAIL invariant_skid_main: skid_valid=1 main_valid=0, want main_valid=1");
      end
      checks++;
      if (!out_valid && out_ctrl !== '0) begin
        errors++;
        $display("FAIL bubble_ctrl: got %0h, want 0", out_ctrl);
      end
      checks++;
      if (in_ready !== (occupancy != 2'd2)) begin
        errors++;
        $display("FAIL ready_vs_occ: in_ready=%0b occupancy=%0d", in_ready, occupancy);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic push_in(input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = rand_data();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1 ||
        occupancy !== 2'd0 || stall_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: v=%0b c=%0h d=%0h r=%0b occ=%0d st=%0d, want 0,0,0,1,0,0",
               out_valid, out_ctrl, out_data, in_ready, occupancy, stall_count);
    end
    reset = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: v=%0b r=%0b occ=%0d, want 0,1,0", out_valid, in_ready,
               occupancy);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_in(CW'(i));
      last_data = in_data;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== CW'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: v=%0b c=%0h occ=%0d r=%0b, want 1,%0h,1,1", i, out_valid,
                 out_ctrl, occupancy, in_ready, i);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== last_data || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL bubble_%0d: v=%0b c=%0h d=%0h occ=%0d, want 0,0,%0h,0", i, out_valid,
                 out_ctrl, out_data, occupancy, last_data);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_in(CW'(5));
    step();
    push_in(CW'(6));
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== CW'(5)) begin
      errors++;
      $display("FAIL bp_full: occ=%0d r=%0b c=%0h, want 2,0,5", occupancy, in_ready, out_ctrl);
    end
    push_in(CW'(7));
    step();
    checks++;
    if (occupancy !== 2'd2 || out_ctrl !== CW'(5)) begin
      errors++;
      $display("FAIL bp_hold: occ=%0d c=%0h, want 2,5", occupancy, out_ctrl);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd1 || out_ctrl !== CW'(6) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: occ=%0d c=%0h r=%0b, want 1,6,1", occupancy, out_ctrl, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd1 || out_ctrl !== CW'(7)) begin
      errors++;
      $display("FAIL bp_drain2: occ=%0d c=%0h, want 1,7", occupancy, out_ctrl);
    end
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_empty: occ=%0d v=%0b pending=%0d, want 0,0,0", occupancy, out_valid,
               sb.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push_in(CW'(11));
    step();
    push_in(CW'(12));
    step();
    push_in(CW'(9));
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        out_data !== '0) begin
      errors++;
      $display("FAIL flush_full: v=%0b c=%0h occ=%0d r=%0b d=%0h, want 0,0,0,1,0", out_valid,
               out_ctrl, occupancy, in_ready, out_data);
    end
    // Flush from ONE while the same-cycle push is accepted by the handshake.
    push_in(CW'(13));
    step();
    push_in(CW'(9));
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL flush_drop_%0d: v=%0b c=%0h occ=%0d, want 0,0,0", i, out_valid, out_ctrl,
                 occupancy);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push_in(CW'(21));
    step();
    push_in(CW'(22));
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1 ||
        occupancy !== 2'd0 || stall_count !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: v=%0b c=%0h d=%0h r=%0b occ=%0d st=%0d, want 0,0,0,1,0,0",
               out_valid, out_ctrl, out_data, in_ready, occupancy, stall_count);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    sb.delete();
    push_in(CW'(23));
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd1 || out_ctrl !== CW'(23)) begin
      errors++;
      $display("FAIL post_reset_push: occ=%0d c=%0h, want 1,23", occupancy, out_ctrl);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_stats();
    logic [15:0] want5;
    logic [15:0] want_sat;
`ifdef PIPE_SKID_STAGE_STATS_EN
    want5    = 16'd5;
    want_sat = 16'hFFFF;
`else
    want5    = 16'd0;
    want_sat = 16'd0;
`endif
    do_reset();
    push_in(CW'(31));
    step();
    in_valid = 1'b0;
    repeat (5) step();
    checks++;
    if (stall_count !== want5) begin
      errors++;
      $display("FAIL stall_5: got %0d, want %0d", stall_count, want5);
    end
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall_count !== want5 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: got %0d v=%0b, want %0d,0", stall_count, out_valid, want5);
    end
    out_ready = 1'b0;
    push_in(CW'(32));
    step();
    in_valid = 1'b0;
`ifdef PIPE_SKID_STAGE_STATS_EN
    repeat (70000) step();
`else
    repeat (50) step();
`endif
    checks++;
    if (stall_count !== want_sat) begin
      errors++;
      $display("FAIL stall_sat: got %0h, want %0h", stall_count, want_sat);
    end
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (sb.size() != 0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL final_drain: pending=%0d occ=%0d, want 0,0", sb.size(), occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_bubble();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
